tape_encoder: RTL



---
 rtl/tape_pkg.sv | 19 +
 rtl/tape_bit_timer.sv | 42 ++++
 rtl/tape_encoder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/tape_pkg.sv
// Shared types and default timing for the cassette output encoder.
// Defaults give 1200 bit/s cells at a 42.66 MHz core clock.
package tape_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LEADER,
        SYNC,
        DATA
    } tape_state_t;

    localparam int unsigned TAPE_CELL_CYCLES  = 35550;
    localparam int unsigned TAPE_PULSE_CYCLES = 4266;
    localparam int unsigned TAPE_LEADER_BYTES = 256;

    localparam logic [7:0] TAPE_LEADER_BYTE = 8'hAA;
    localparam logic [7:0] TAPE_SYNC_BYTE   = 8'h66;

endpackage

// File: rtl/tape_bit_timer.sv
// Bit-cell counter: a clock pulse at the start of every cell and a data pulse
// at mid-cell for '1' bits. pulse is combinational; the caller registers it.
module tape_bit_timer
    import tape_pkg::*;
#(
    parameter int unsigned CELL_CYCLES  = TAPE_CELL_CYCLES,
    parameter int unsigned PULSE_CYCLES = TAPE_PULSE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic data_bit,
    input  logic hold,
    output logic pulse,
    output logic cell_end
);

    localparam int unsigned CW = $clog2(CELL_CYCLES);

    localparam logic [CW-1:0] CNT_LAST   = CW'(CELL_CYCLES - 1);
    localparam logic [CW-1:0] CLOCK_END  = CW'(PULSE_CYCLES);
    localparam logic [CW-1:0] DATA_START = CW'(CELL_CYCLES / 2);
    localparam logic [CW-1:0] DATA_END   = CW'(CELL_CYCLES / 2 + PULSE_CYCLES);

    logic [CW-1:0] cnt;

    // While held the counter parks at 0 and the line stays quiet.
    assign cell_end = ~hold & (cnt == CNT_LAST);
    assign pulse    = ~hold & ((cnt < CLOCK_END) |
                               (data_bit & (cnt >= DATA_START) & (cnt < DATA_END)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (start | hold | cell_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tape_encoder.sv
// Cassette output serializer: leader, sync byte, then handshaked payload
// bytes, each sent MSB first as pulse-coded bit cells.
module tape_encoder
    import tape_pkg::*;
#(
    parameter int unsigned CELL_CYCLES  = TAPE_CELL_CYCLES,
    parameter int unsigned PULSE_CYCLES = TAPE_PULSE_CYCLES,
    parameter int unsigned LEADER_BYTES = TAPE_LEADER_BYTES,
    parameter logic [7:0]  LEADER_BYTE  = TAPE_LEADER_BYTE,
    parameter logic [7:0]  SYNC_BYTE    = TAPE_SYNC_BYTE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_last,
    input  logic       abort,
    output logic       tape_out,
    output logic       busy,
    output logic       done
);

    localparam logic [15:0] LEADER_LAST = 16'(LEADER_BYTES - 1);

    tape_state_t state, state_next;
    logic [7:0]  shift, shift_next;
    logic [2:0]  bit_cnt, bit_cnt_next;
    logic [15:0] byte_cnt, byte_cnt_next;
    logic        need_byte, need_next;
    logic        last_flag, last_next;
    logic        done_next;
    logic        accept, hold, pulse, cell_end, byte_end;

    assign in_ready = (state == DATA) & need_byte & ~abort;
    assign accept   = in_ready & in_valid;
    assign hold     = (state == IDLE) | ((state == DATA) & need_byte);
    assign byte_end = cell_end & (bit_cnt == 3'd7);

    tape_bit_timer #(
        .CELL_CYCLES (CELL_CYCLES),
        .PULSE_CYCLES(PULSE_CYCLES)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .start   (abort | accept),
        .data_bit(shift[7]),
        .hold    (hold),
        .pulse   (pulse),
        .cell_end(cell_end)
    );

    always_comb begin
        state_next    = state;
        shift_next    = shift;
        bit_cnt_next  = bit_cnt;
        byte_cnt_next = byte_cnt;
        need_next     = need_byte;
        last_next     = last_flag;
        done_next     = 1'b0;

        if (cell_end) begin
            shift_next   = {shift[6:0], 1'b0};
            bit_cnt_next = bit_cnt + 3'd1;
        end

        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next    = LEADER;
                    shift_next    = LEADER_BYTE;
                    bit_cnt_next  = '0;
                    byte_cnt_next = '0;
                end
            end
            LEADER: begin
                if (byte_end) begin
                    if (byte_cnt == LEADER_LAST) begin
                        state_next = SYNC;
                        shift_next = SYNC_BYTE;
                    end else begin
                        byte_cnt_next = byte_cnt + 16'd1;
                        shift_next    = LEADER_BYTE;
                    end
                end
            end
            SYNC: begin
                if (byte_end) begin
                    state_next = DATA;
                    need_next  = 1'b1;
                end
            end
            DATA: begin
                if (accept) begin
                    shift_next   = in_data;
                    last_next    = in_last;
                    need_next    = 1'b0;
                    bit_cnt_next = '0;
                end else if (byte_end) begin
                    if (last_flag) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        need_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Cancel outranks everything, including a same-cycle accept.
        if (abort) begin
            state_next    = IDLE;
            shift_next    = '0;
            bit_cnt_next  = '0;
            byte_cnt_next = '0;
            need_next     = 1'b0;
            last_next     = 1'b0;
            done_next     = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift     <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            need_byte <= 1'b0;
            last_flag <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            tape_out  <= 1'b0;
        end else begin
            state     <= state_next;
            shift     <= shift_next;
            bit_cnt   <= bit_cnt_next;
            byte_cnt  <= byte_cnt_next;
            need_byte <= need_next;
            last_flag <= last_next;
            done      <= done_next;
            busy      <= (state_next != IDLE);
            tape_out  <= pulse & ~abort;
        end
    end

endmodule
